// File: rtl/md5_host_sequencer.sv
// Host-side sequencer for the MD5 cracker: streams the configuration words,
// polls the match flag, reads back the result and reports it.
module md5_host_sequencer #(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 2,
    parameter int POLL_INTERVAL = 1024,
    parameter int MAX_POLLS     = 0
) (
    input  logic         clk,
    input  logic         reset2,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] target,
    input  logic [7:0]   range_min,
    input  logic [7:0]   range_max,
    output logic [31:0]  cmd_data,
    output logic         cmd_strobe,
    input  logic [31:0]  resp_data,
    input  logic         matched,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic         timed_out,
    output logic [127:0] found_text,
    output logic [63:0]  attempts
);

    localparam int WORD_CYCLES = 1 + STROBE_CYCLES + GAP_CYCLES;
    localparam int CYC_W       = $clog2(WORD_CYCLES);
    localparam int WAIT_W      = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CYC_W-1:0]  LAST_CYC  = CYC_W'(WORD_CYCLES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        IDLE, CFG, RUN_WAIT, RUN_CHECK, READ, FIN, ABORT
    } state_t;

    state_t              state;
    logic [CYC_W-1:0]    cyc;
    logic [3:0]          word_idx;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         poll_cnt;
    logic                abort_pend;
    logic [127:0]        tgt_q;
    logic [7:0]          min_q;
    logic [7:0]          max_q;

    logic word_state;
    logic word_last;
    logic abort_window;
    logic abort_req;

    assign word_state   = (state == CFG) || (state == READ) || (state == ABORT);
    assign word_last    = word_state && (cyc == LAST_CYC);
    assign abort_window = (state == CFG) || (state == RUN_WAIT) ||
                          (state == RUN_CHECK) || (state == READ);
    assign abort_req    = abort | abort_pend;

    function automatic logic [31:0] cfg_word(input logic [3:0] idx, input logic [127:0] t,
                                             input logic [7:0] mn, input logic [7:0] mx);
        case (idx)
            4'd0:    cfg_word = 32'h5230_0000;
            4'd1:    cfg_word = 32'h5230_1000;
            4'd2:    cfg_word = t[31:0];
            4'd3:    cfg_word = 32'h5230_1001;
            4'd4:    cfg_word = t[63:32];
            4'd5:    cfg_word = 32'h5230_1002;
            4'd6:    cfg_word = t[95:64];
            4'd7:    cfg_word = 32'h5230_1003;
            4'd8:    cfg_word = t[127:96];
            4'd9:    cfg_word = 32'h5230_2000;
            4'd10:   cfg_word = {16'h0, mx, mn};
            default: cfg_word = 32'h5230_0001;
        endcase
    endfunction

    function automatic logic [31:0] read_word(input logic [3:0] idx);
        case (idx)
            4'd0:    read_word = 32'h4400_0001;
            4'd1:    read_word = 32'h4400_0002;
            4'd2:    read_word = 32'h4400_0003;
            4'd3:    read_word = 32'h5230_3000;
            default: read_word = 32'h5230_3001;
        endcase
    endfunction

    // Word timing is a cycle counter per word: 0 is SETUP, then strobe, then gap.
    // Aborts are only acted on at word boundaries so a strobe is never cut short.
    always_ff @(posedge clk or posedge reset2) begin
        if (reset2) begin
            state      <= IDLE;
            cyc        <= '0;
            word_idx   <= '0;
            wait_cnt   <= '0;
            poll_cnt   <= '0;
            abort_pend <= 1'b0;
            tgt_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            cmd_data   <= '0;
            cmd_strobe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            timed_out  <= 1'b0;
            found_text <= '0;
            attempts   <= '0;
        end else begin
            done <= 1'b0;
            if (word_state && !word_last) begin
                cyc        <= cyc + CYC_W'(1);
                cmd_strobe <= (int'(cyc) + 1 <= STROBE_CYCLES);
            end
            if (abort && abort_window) begin
                abort_pend <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        tgt_q      <= target;
                        min_q      <= range_min;
                        max_q      <= range_max;
                        found      <= 1'b0;
                        timed_out  <= 1'b0;
                        found_text <= '0;
                        attempts   <= '0;
                        poll_cnt   <= '0;
                        abort_pend <= 1'b0;
                        word_idx   <= '0;
                        cyc        <= '0;
                        cmd_data   <= cfg_word(4'd0, target, range_min, range_max);
                        busy       <= 1'b1;
                        state      <= CFG;
                    end
                end

                CFG: begin
                    if (word_last) begin
                        if (abort_req) begin
                            state      <= ABORT;
                            cyc        <= '0;
                            cmd_data   <= 32'h5230_0000;
                            found      <= 1'b0;
                            timed_out  <= 1'b0;
                            abort_pend <= 1'b0;
                        end else if (word_idx == 4'd11) begin
                            wait_cnt <= '0;
                            state    <= RUN_WAIT;
                        end else begin
                            word_idx <= word_idx + 4'd1;
                            cyc      <= '0;
                            cmd_data <= cfg_word(word_idx + 4'd1, tgt_q, min_q, max_q);
                        end
                    end
                end

                RUN_WAIT: begin
                    if (abort_req) begin
                        state      <= ABORT;
                        cyc        <= '0;
                        cmd_data   <= 32'h5230_0000;
                        found      <= 1'b0;
                        timed_out  <= 1'b0;
                        abort_pend <= 1'b0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= RUN_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                // The only place matched is looked at; the poll counter saturates.
                RUN_CHECK: begin
                    if (abort_req) begin
                        state      <= ABORT;
                        cyc        <= '0;
                        cmd_data   <= 32'h5230_0000;
                        found      <= 1'b0;
                        timed_out  <= 1'b0;
                        abort_pend <= 1'b0;
                    end else if (matched) begin
                        found    <= 1'b1;
                        word_idx <= '0;
                        cyc      <= '0;
                        cmd_data <= read_word(4'd0);
                        state    <= READ;
                    end else begin
                        if (poll_cnt != 32'hFFFF_FFFF) begin
                            poll_cnt <= poll_cnt + 32'd1;
                        end
                        if (MAX_POLLS != 0 && poll_cnt + 32'd1 == 32'(MAX_POLLS)) begin
                            timed_out <= 1'b1;
                            word_idx  <= '0;
                            cyc       <= '0;
                            cmd_data  <= read_word(4'd0);
                            state     <= READ;
                        end else begin
                            wait_cnt <= '0;
                            state    <= RUN_WAIT;
                        end
                    end
                end

                READ: begin
                    if (word_last) begin
                        case (word_idx)
                            4'd0:    found_text[31:0]  <= resp_data;
                            4'd1:    found_text[63:32] <= resp_data;
                            4'd2:    found_text[95:64] <= resp_data;
                            4'd3:    attempts[31:0]    <= resp_data;
                            default: attempts[63:32]   <= resp_data;
                        endcase
                        if (abort_req) begin
                            state      <= ABORT;
                            cyc        <= '0;
                            cmd_data   <= 32'h5230_0000;
                            found      <= 1'b0;
                            timed_out  <= 1'b0;
                            abort_pend <= 1'b0;
                        end else if (word_idx == 4'd4) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            word_idx <= word_idx + 4'd1;
                            cyc      <= '0;
                            cmd_data <= read_word(word_idx + 4'd1);
                        end
                    end
                end

                ABORT: begin
                    if (word_last) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md5_host_sequencer.sv
// Scoreboard bench for md5_host_sequencer with a behavioural cracker model.
module tb_md5_host_sequencer;

    localparam int POLL    = 8;
    localparam int MAXP    = 4;
    localparam int WORD    = 5;
    localparam int CFG_END = 12 * WORD;

    logic         clk = 1'b0;
    logic         reset2 = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         matched = 1'b0;
    logic [127:0] target = '0;
    logic [7:0]   range_min = '0;
    logic [7:0]   range_max = '0;
    logic [31:0]  resp_data = '0;
    logic [31:0]  cmd_data;
    logic         cmd_strobe;
    logic         busy;
    logic         done;
    logic         found;
    logic         timed_out;
    logic [127:0] found_text;
    logic [63:0]  attempts;

    md5_host_sequencer #(
        .STROBE_CYCLES(2),
        .GAP_CYCLES(2),
        .POLL_INTERVAL(POLL),
        .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .reset2(reset2), .start(start), .abort(abort),
        .target(target), .range_min(range_min), .range_max(range_max),
        .cmd_data(cmd_data), .cmd_strobe(cmd_strobe),
        .resp_data(resp_data), .matched(matched),
        .busy(busy), .done(done), .found(found), .timed_out(timed_out),
        .found_text(found_text), .attempts(attempts)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] w; int off; } word_t;
    typedef struct { logic f; logic t; logic [127:0] txt; logic [63:0] att; } res_t;

    word_t       wq[$];
    res_t        rq[$];
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    int          start_edge = 0;
    int          exp_done = 0;
    int          done_cnt = 0;
    logic [31:0] crk_text [3];
    logic [63:0] crk_att = '0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] cfgWord(input int k, input logic [127:0] t,
                                            input logic [7:0] mn, input logic [7:0] mx);
        logic [31:0] w [12];
        w = '{32'h52300000, 32'h52301000, t[31:0], 32'h52301001, t[63:32],
              32'h52301002, t[95:64], 32'h52301003, t[127:96], 32'h52302000,
              {16'h0, mx, mn}, 32'h52300001};
        return w[k];
    endfunction

    function automatic logic [31:0] readWord(input int k);
        logic [31:0] w [5];
        w = '{32'h44000001, 32'h44000002, 32'h44000003, 32'h52303000, 32'h52303001};
        return w[k];
    endfunction

    // Behavioural cracker: answers read commands while the strobe is high.
    initial forever begin
        @(negedge clk);
        if (cmd_strobe) begin
            case (cmd_data)
                32'h44000001: resp_data = crk_text[0];
                32'h44000002: resp_data = crk_text[1];
                32'h44000003: resp_data = crk_text[2];
                32'h52303000: resp_data = crk_att[31:0];
                32'h52303001: resp_data = crk_att[63:32];
                default:      resp_data = $urandom;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every strobe rise and every done pulse.
    initial begin
        logic        prev_strobe;
        logic        prev_done;
        logic [31:0] prev_data;
        int          hi_cnt;
        int          rel;
        word_t       ew;
        res_t        er;
        prev_strobe = 1'b0;
        prev_done   = 1'b0;
        prev_data   = '0;
        hi_cnt      = 0;
        forever begin
            @(negedge clk);
            if (reset2) begin
                prev_strobe = 1'b0;
                prev_done   = 1'b0;
                hi_cnt      = 0;
            end else begin
                rel = edge_n - start_edge;
                if (cmd_strobe && !prev_strobe) begin
                    checkOutput("word_expected", 128'(wq.size() != 0), 128'(1));
                    if (wq.size() != 0) begin
                        ew = wq.pop_front();
                        checkOutput("cmd_word", 128'(cmd_data), 128'(ew.w));
                        checkOutput("word_edge", 128'(rel), 128'(ew.off));
                    end
                    hi_cnt = 1;
                end else if (cmd_strobe && prev_strobe) begin
                    checkOutput("data_stable", 128'(cmd_data), 128'(prev_data));
                    hi_cnt++;
                end else if (!cmd_strobe && prev_strobe) begin
                    checkOutput("strobe_width", 128'(hi_cnt), 128'(2));
                end
                if (done) begin
                    done_cnt++;
                    checkOutput("busy_in_fin", 128'(busy), 128'(1));
                    checkOutput("result_expected", 128'(rq.size() != 0), 128'(1));
                    if (rq.size() != 0) begin
                        er = rq.pop_front();
                        checkOutput("found", 128'(found), 128'(er.f));
                        checkOutput("timed_out", 128'(timed_out), 128'(er.t));
                        checkOutput("found_text", found_text, er.txt);
                        checkOutput("attempts", 128'(attempts), 128'(er.att));
                    end
                end
                if (prev_done) begin
                    checkOutput("done_pulse", 128'(done), 128'(0));
                    checkOutput("idle_after_done", 128'(busy), 128'(0));
                end
                prev_strobe = cmd_strobe;
                prev_data   = cmd_data;
                prev_done   = done;
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_strobe"}, 128'(cmd_strobe), 128'(0));
        checkOutput({tag, "_cmd_data"}, 128'(cmd_data), 128'(0));
        checkOutput({tag, "_busy"}, 128'(busy), 128'(0));
        checkOutput({tag, "_done"}, 128'(done), 128'(0));
        checkOutput({tag, "_found"}, 128'(found), 128'(0));
        checkOutput({tag, "_timed_out"}, 128'(timed_out), 128'(0));
        checkOutput({tag, "_found_text"}, found_text, 128'(0));
        checkOutput({tag, "_attempts"}, 128'(attempts), 128'(0));
    endtask

    // One crack run. m: poll index that sees matched (>MAXP: never);
    // abort_edge: start-relative edge that samples abort (0: none);
    // reset_at: start-relative edge after which reset2 is raised (-1: none).
    task automatic applyStimulus(input logic [127:0] tgt, input logic [7:0] mn, input logic [7:0] mx,
                                 input int m, input int abort_edge, input bit start_in_read,
                                 input int reset_at, input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic [63:0] att);
        word_t w;
        res_t  r;
        int    rel;
        int    j;
        int    r_edge;
        bit    seen_done;
        bit    glitch;
        crk_text[0] = t0;
        crk_text[1] = t1;
        crk_text[2] = t2;
        crk_att     = att;
        r_edge = (m <= MAXP) ? CFG_END + (POLL + 1) * m : CFG_END + (POLL + 1) * MAXP;

        @(negedge clk);
        target     = tgt;
        range_min  = mn;
        range_max  = mx;
        start      = 1'b1;
        start_edge = edge_n + 1;

        if (abort_edge >= 1 && abort_edge <= CFG_END) begin
            j = (abort_edge - 1) / WORD;
            for (int k = 0; k <= j; k++) begin
                w.w = cfgWord(k, tgt, mn, mx); w.off = WORD * k + 1; wq.push_back(w);
            end
            w.w = 32'h52300000; w.off = WORD * (j + 1) + 1; wq.push_back(w);
        end else begin
            for (int k = 0; k < 12; k++) begin
                w.w = cfgWord(k, tgt, mn, mx); w.off = WORD * k + 1; wq.push_back(w);
            end
            if (abort_edge > CFG_END) begin
                w.w = 32'h52300000; w.off = abort_edge + 1; wq.push_back(w);
            end else begin
                for (int k = 0; k < 5; k++) begin
                    w.w = readWord(k); w.off = r_edge + 1 + WORD * k; wq.push_back(w);
                end
            end
        end
        if (abort_edge != 0) begin
            r.f = 1'b0; r.t = 1'b0; r.txt = '0; r.att = '0;
        end else begin
            r.f = (m <= MAXP); r.t = (m > MAXP); r.txt = {32'h0, t2, t1, t0}; r.att = att;
        end
        rq.push_back(r);
        exp_done++;

        @(negedge clk);
        start     = 1'b0;
        target    = {$urandom, $urandom, $urandom, $urandom};
        range_min = 8'($urandom);
        range_max = 8'($urandom);

        seen_done = 1'b0;
        for (int n = 0; n < 400; n++) begin
            rel = edge_n - start_edge;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (rel == reset_at) begin
                checkOutput("strobe_before_reset", 128'(cmd_strobe), 128'(1));
                reset2 = 1'b1;
                #1;
                checkAllZero("mid_reset");
                wq.delete();
                exp_done -= rq.size();
                rq.delete();
                matched = 1'b0;
                abort   = 1'b0;
                repeat (2) @(negedge clk);
                reset2 = 1'b0;
                return;
            end
            glitch = (rel + 1 == 30);
            for (int k = 1; k < m && k <= MAXP; k++) begin
                if (rel + 1 == CFG_END + (POLL + 1) * k - 3) glitch = 1'b1;
            end
            matched = glitch || (m <= MAXP && rel + 1 >= CFG_END + (POLL + 1) * m);
            abort   = (abort_edge != 0 && rel + 1 == abort_edge);
            start   = start_in_read && (rel + 1 == r_edge + 3);
            @(negedge clk);
        end
        checkOutput("run_finished", 128'(seen_done), 128'(1));
        matched = 1'b0;
        abort   = 1'b0;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("words_consumed", 128'(wq.size()), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int m;
        int kind;
        int ae;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset2 = 1'b0;
        repeat (2) @(negedge clk);

        // Config trace plus match on the 2nd poll with the reference cracker data.
        applyStimulus(128'h0123456789ABCDEF0123456789ABCDEF, 8'h61, 8'h7A, 2, 0, 1'b0, -1,
                      32'h64636261, 32'h0, 32'h0, 64'h1000);
        // Timeout: never matched.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'h30, 8'h39, 6, 0, 1'b0, -1,
                      $urandom, $urandom, $urandom, {$urandom, $urandom});
        // Abort while waiting to poll.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'h41, 8'h5A, 6, 64, 1'b0, -1,
                      $urandom, $urandom, $urandom, {$urandom, $urandom});
        // Start pulsed during READ must be ignored.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'h61, 8'h7A, 1, 0, 1'b1, -1,
                      $urandom, $urandom, $urandom, {$urandom, $urandom});
        // Reset in the 2nd strobe cycle of the 4th word, then a full run.
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'h61, 8'h7A, 3, 0, 1'b0, 17,
                      $urandom, $urandom, $urandom, {$urandom, $urandom});
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'h61, 8'h7A, 3, 0, 1'b0, -1,
                      $urandom, $urandom, $urandom, {$urandom, $urandom});

        // Start and abort together in IDLE: nothing happens.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("start_abort_ignored", 128'(busy), 128'(0));

        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 3);
            m    = $urandom_range(1, 6);
            ae   = 0;
            if (kind == 2) begin
                ae = $urandom_range(1, CFG_END);
                m  = 6;
            end else if (kind == 3) begin
                ae = $urandom_range(CFG_END + 1, CFG_END + POLL);
                m  = 6;
            end
            applyStimulus({$urandom, $urandom, $urandom, $urandom}, 8'($urandom), 8'($urandom),
                          m, ae, 1'($urandom), -1,
                          $urandom, $urandom, $urandom, {$urandom, $urandom});
        end

        checkOutput("done_count", 128'(done_cnt), 128'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
